// File: rtl/four_bit_signed_serial_subtractor.sv
// four_bit_signed_serial_subtractor: bit-serial D = A - B - borrowIn, LSB first, with zero/neg/overflow/borrow flags.
// Define SUB_SATURATE_EN to clamp d on signed overflow.
module four_bit_signed_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             borrowIn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] d,
    output logic             zeroFlag,
    output logic             negFlag,
    output logic             overflowFlag,
    output logic             borrowFlag,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, am_q, am_d, bm_q, bm_d;
    logic             z_q, z_d, n_q, n_d, o_q, o_d, bf_q, bf_d;
    logic             diff, last, ovf;
    logic [WIDTH-1:0] res, sat;

    assign diff = a_q[0] ^ b_q[0] ^ br_q;
    assign res  = {diff, res_q[WIDTH-1:1]};
    assign last = cnt_q == CW'(WIDTH - 1);
    // the final diff bit is the raw MSB, so overflow is judged before any clamping
    assign ovf  = (am_q != bm_q) && (diff != am_q);
`ifdef SUB_SATURATE_EN
    assign sat  = ovf ? {am_q, {(WIDTH-1){~am_q}}} : res;
`else
    assign sat  = res;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        am_d    = am_q;
        bm_d    = bm_q;
        dout_d  = dout_q;
        z_d     = z_q;
        n_d     = n_q;
        o_d     = o_q;
        bf_d    = bf_q;
        case (state_q)
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res;
                br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    dout_d  = sat;
                    z_d     = sat == '0;
                    n_d     = sat[WIDTH-1];
                    o_d     = ovf;
                    bf_d    = br_d;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    a_d     = A;
                    b_d     = B;
                    br_d    = borrowIn;
                    cnt_d   = '0;
                    am_d    = A[WIDTH-1];
                    bm_d    = B[WIDTH-1];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            dout_q  <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
            o_q     <= 1'b0;
            bf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
            dout_q  <= dout_d;
            z_q     <= z_d;
            n_q     <= n_d;
            o_q     <= o_d;
            bf_q    <= bf_d;
        end
    end

    assign d            = dout_q;
    assign zeroFlag     = z_q;
    assign negFlag      = n_q;
    assign overflowFlag = o_q;
    assign borrowFlag   = bf_q;
    assign busy         = state_q == SHIFT;
    assign done         = state_q == DONE;
endmodule

// File: tb/tb_four_bit_signed_serial_subtractor.sv
// tb_four_bit_signed_serial_subtractor: scoreboard bench for the serial subtractor.
// Expected results come from an arithmetic model; SUB_SATURATE_EN selects the clamped model.
module tb_four_bit_signed_serial_subtractor;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, borrowIn = 1'b0;
    logic [3:0] A = 4'h0, B = 4'h0;
    logic [3:0] d;
    logic       zeroFlag, negFlag, overflowFlag, borrowFlag, busy, done;
    int         tests = 0, fails = 0;

    typedef struct packed {
        logic [3:0] d;
        logic       z, n, o, b;
    } exp_t;

    exp_t sb[$];

    four_bit_signed_serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .borrowIn(borrowIn), .A(A), .B(B),
        .d(d), .zeroFlag(zeroFlag), .negFlag(negFlag), .overflowFlag(overflowFlag),
        .borrowFlag(borrowFlag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic bin);
        exp_t e;
        int   s;
        s   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.o = (s > 7) || (s < -8);
        e.b = int'(a) < int'(b) + int'(bin);
        e.d = s[3:0];
`ifdef SUB_SATURATE_EN
        if (e.o) e.d = (s > 7) ? 4'b0111 : 4'b1000;
`endif
        e.z = e.d == 4'h0;
        e.n = e.d[3];
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: d=%b with no result pending", d);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({d, zeroFlag, negFlag, overflowFlag, borrowFlag} !== e) begin
                    fails++;
                    $display("FAIL result: got d=%b z%b n%b o%b b%b, want d=%b z%b n%b o%b b%b",
                             d, zeroFlag, negFlag, overflowFlag, borrowFlag, e.d, e.z, e.n, e.o, e.b);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; borrowIn = bin; start = 1'b1;
        sb.push_back(model(a, b, bin));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL done_timeout: done=%b, want 1 within 10 cycles", done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({d, zeroFlag, negFlag, overflowFlag, borrowFlag, busy, done} !== 10'b0000_1000_00) begin
            fails++;
            $display("FAIL reset: got %b, want 0000100000",
                     {d, zeroFlag, negFlag, overflowFlag, borrowFlag, busy, done});
        end
    endtask

    task automatic test_basic();
        issue(4'b0011, 4'b0101, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if ({busy, done} !== 2'b10) begin
                fails++;
                $display("FAIL busy_window[%0d]: busy/done=%b, want 10", i, {busy, done});
            end
        end
        @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b01) begin
            fails++;
            $display("FAIL done_latency: busy/done=%b, want 01", {busy, done});
        end
        @(negedge clk);
        tests++;
        if ({busy, done, d} !== 6'b00_1110) begin
            fails++;
            $display("FAIL done_pulse_hold: busy/done/d=%b, want 001110", {busy, done, d});
        end
    endtask

    task automatic test_zero_back_to_back();
        issue(4'b0101, 4'b0101, 1'b0);
        wait_done();
        A = 4'b0100; B = 4'b0010; borrowIn = 1'b1; start = 1'b1;
        sb.push_back(model(4'b0100, 4'b0010, 1'b1));
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, done} !== 2'b10) begin
            fails++;
            $display("FAIL back_to_back_accept: busy/done=%b, want 10", {busy, done});
        end
        wait_done();
    endtask

    task automatic test_overflow();
        issue(4'b0111, 4'b1111, 1'b0);
        wait_done();
        issue(4'b1000, 4'b0001, 1'b0);
        wait_done();
    endtask

    task automatic test_ignore_inputs();
        issue(4'b0110, 4'b0011, 1'b0);
        A = 4'b1111; B = 4'b1000; borrowIn = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL return_idle: busy/done=%b, want 00", {busy, done});
        end
    endtask

    task automatic test_abort();
        bit bad = 0;
        @(negedge clk);
        A = 4'b0010; B = 4'b0111; borrowIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 4'b1001; B = 4'b0001;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst_n = 1'b0;
        #1;
        tests++;
        if ({d, zeroFlag, negFlag, overflowFlag, borrowFlag, busy, done} !== 10'b0000_1000_00) begin
            fails++;
            $display("FAIL abort_reset: got %b, want 0000100000",
                     {d, zeroFlag, negFlag, overflowFlag, borrowFlag, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || done) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL abort_quiet: busy/done seen after release, want 00");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            issue(4'($urandom), 4'($urandom), 1'($urandom));
            wait_done();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_back_to_back();
        test_overflow();
        test_ignore_inputs();
        test_abort();
        test_random();
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
